// File: rtl/nv_fifo_ctrl_60x42.sv
// nv_fifo_ctrl_60x42: valid/ready FIFO controller wrapping a 2-cycle-latency 60x42 two-port RAM
module nv_fifo_ctrl_60x42 #(
  parameter int DEPTH = 60,
  parameter int WIDTH = 42,
  parameter int AW    = 6
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_pd,
  output logic [6:0]       fifo_count,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_ore,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  input  logic [WIDTH-1:0] ram_dout
);
  localparam logic [6:0]    LP_DEPTH = 7'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [6:0]    r_count;
  logic [6:0]    r_pend;
  logic          r_s1_vld;
  logic          r_s2_vld;
  logic          w_push;
  logic          w_pop;
  logic          w_adv;
  logic          w_issue;

  // Handshakes and read-pipe advance; wr_ready depends only on registered occupancy
  always_comb begin
    wr_ready = r_count < LP_DEPTH;
    w_push   = wr_valid & wr_ready;
    w_pop    = r_s2_vld & rd_ready;
    w_adv    = r_s1_vld & (~r_s2_vld | w_pop);
    w_issue  = (r_pend != 7'd0) & (~r_s1_vld | w_adv);
  end

  assign rd_valid    = r_s2_vld;
  assign rd_pd       = ram_dout;
  assign fifo_count  = r_count;
  assign ram_we      = w_push;
  assign ram_wa      = r_wr_ptr;
  assign ram_di      = wr_pd;
  assign ram_re      = w_issue;
  assign ram_ra      = r_rd_ptr;
  assign ram_ore     = w_adv;
  assign ram_byp_sel = 1'b0;
  assign ram_dbyp    = '0;

  // Pointers wrap explicitly at DEPTH-1 since DEPTH is not a power of two
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Occupancy frees a slot only at pop; pend tracks written-but-unissued entries
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_count <= '0;
      r_pend  <= '0;
    end else begin
      r_count <= r_count + 7'(w_push) - 7'(w_pop);
      r_pend  <= r_pend + 7'(w_push) - 7'(w_issue);
    end
  end

  // Read pipe: s1 = address latched in RAM, s2 = data in RAM output register
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_issue | (r_s1_vld & ~w_adv);
      r_s2_vld <= w_adv | (r_s2_vld & ~w_pop);
    end
  end
endmodule

// File: tb/tb_nv_fifo_ctrl_60x42.sv
// tb_nv_fifo_ctrl_60x42: directed bench with a behavioural RAM and an in-order scoreboard
module tb_nv_fifo_ctrl_60x42;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [41:0] wr_pd = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [41:0] rd_pd;
  logic [6:0]  fifo_count;
  logic        ram_we;
  logic [5:0]  ram_wa;
  logic [41:0] ram_di;
  logic        ram_re;
  logic [5:0]  ram_ra;
  logic        ram_ore;
  logic        ram_byp_sel;
  logic [41:0] ram_dbyp;
  logic [41:0] ram_dout;

  logic [41:0] mem [0:59];
  logic [5:0]  ra_d;
  logic [41:0] dout_r;

  int          checks = 0;
  int          failures = 0;
  logic [41:0] exp_q[$];
  int          m_cnt = 0;
  bit          prev_stall = 0;
  logic [41:0] prev_pd = '0;
  logic [41:0] next_word = '0;
  logic [15:0] lfsr = 16'hACE1;

  always #5 clk = ~clk;

  nv_fifo_ctrl_60x42 dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pd(wr_pd),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pd(rd_pd),
    .fifo_count(fifo_count),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
    .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_d <= ram_ra;
    if (ram_ore) dout_r <= mem[ra_d];
  end
  assign ram_dout = dout_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic stream_cycle(input bit wv, input logic [41:0] wd, input bit rr);
    wr_valid = wv;
    wr_pd    = wd;
    rd_ready = rr;
    #1;
    checks++;
    if (wr_ready !== (m_cnt < 60)) begin
      failures++;
      $display("FAIL wr_ready: got %0b expected %0b", wr_ready, m_cnt < 60);
    end
    checks++;
    if (fifo_count !== 7'(m_cnt)) begin
      failures++;
      $display("FAIL fifo_count: got %0d expected %0d", fifo_count, m_cnt);
    end
    if (prev_stall) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_pd !== prev_pd) begin
        failures++;
        $display("FAIL stall_hold: got v=%0b pd=%0h expected v=1 pd=%0h", rd_valid, rd_pd, prev_pd);
      end
    end
    if (rd_valid === 1'b1 && rr) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_order: got %0h expected no data", rd_pd);
      end else begin
        if (rd_pd !== exp_q[0]) begin
          failures++;
          $display("FAIL pop_order: got %0h expected %0h", rd_pd, exp_q[0]);
        end
        void'(exp_q.pop_front());
        m_cnt--;
      end
    end
    if (wv && m_cnt + ((rd_valid === 1'b1 && rr) ? 1 : 0) < 60) begin
      exp_q.push_back(wd);
      m_cnt++;
    end
    prev_stall = (rd_valid === 1'b1) && !rr;
    prev_pd    = rd_pd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    prev_stall = 0;
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    chk("rst_re", 64'(ram_re), 64'd0);
    chk("rst_ore", 64'(ram_ore), 64'd0);
    chk("rst_wa", 64'(ram_wa), 64'd0);
    chk("rst_ra", 64'(ram_ra), 64'd0);
    chk("byp_sel", 64'(ram_byp_sel), 64'd0);
    chk("dbyp", 64'(ram_dbyp), 64'd0);
  endtask

  task automatic test_single();
    wr_valid = 1'b1;
    wr_pd = 42'h155_5555_5555;
    #1;
    chk("c0_we", 64'(ram_we), 64'd1);
    chk("c0_wa", 64'(ram_wa), 64'd0);
    chk("c0_di", 64'(ram_di), 64'h155_5555_5555);
    chk("c0_re", 64'(ram_re), 64'd0);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("c1_re", 64'(ram_re), 64'd1);
    chk("c1_ra", 64'(ram_ra), 64'd0);
    chk("c1_valid", 64'(rd_valid), 64'd0);
    chk("c1_count", 64'(fifo_count), 64'd1);
    tick();
    chk("c2_ore", 64'(ram_ore), 64'd1);
    chk("c2_re", 64'(ram_re), 64'd0);
    chk("c2_valid", 64'(rd_valid), 64'd0);
    tick();
    rd_ready = 1'b1;
    #1;
    chk("c3_valid", 64'(rd_valid), 64'd1);
    chk("c3_pd", 64'(rd_pd), 64'h155_5555_5555);
    tick();
    chk("c4_valid", 64'(rd_valid), 64'd0);
    chk("c4_count", 64'(fifo_count), 64'd0);
    rd_ready = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 60; i++) stream_cycle(1'b1, 42'(i), 1'b0);
    wr_valid = 1'b1;
    wr_pd = 42'd999;
    #1;
    chk("full_count", 64'(fifo_count), 64'd60);
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    chk("full_no_we", 64'(ram_we), 64'd0);
    chk("full_head", 64'(rd_pd), 64'd0);
    for (int i = 0; i < 3; i++) stream_cycle(1'b1, 42'd999, 1'b0);
    chk("full_hold_count", 64'(fifo_count), 64'd60);
    next_word = 42'd60;
  endtask

  task automatic test_back_to_back();
    stream_cycle(1'b1, next_word, 1'b1);
    chk("pop_in_full_no_push", 64'(fifo_count), 64'd59);
    for (int i = 0; i < 90; i++) begin
      stream_cycle(1'b1, next_word, 1'b1);
      next_word++;
      if (i >= 2) begin
        chk("steady_valid", 64'(rd_valid), 64'd1);
        chk("steady_count", 64'(fifo_count), 64'd59);
      end
    end
  endtask

  task automatic test_random_stall();
    int sent;
    int guard;
    sent = 0;
    guard = 0;
    while (sent < 200 && guard < 5000) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (m_cnt < 60 || (rd_valid && lfsr[0])) begin
        stream_cycle(1'b1, {lfsr, 26'(next_word)}, lfsr[0]);
        sent++;
        next_word++;
      end else stream_cycle(1'b0, '0, lfsr[0]);
      guard++;
    end
    chk("rand_sent", 64'(sent), 64'd200);
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      stream_cycle(1'b0, '0, 1'b1);
      guard++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_count", 64'(fifo_count), 64'd0);
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 10; i++) stream_cycle(1'b1, 42'h3A0 + 42'(i), 1'b0);
    chk("mid_count", 64'(fifo_count), 64'd10);
    do_reset();
    chk("mid_rst_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
    wr_valid = 1'b1;
    wr_pd = 42'h2AA_AAAA_AAAA;
    #1;
    chk("mid_push_wa", 64'(ram_wa), 64'd0);
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    #1;
    chk("mid_n1_valid", 64'(rd_valid), 64'd0);
    tick();
    chk("mid_n2_valid", 64'(rd_valid), 64'd0);
    tick();
    chk("mid_n3_valid", 64'(rd_valid), 64'd1);
    chk("mid_n3_pd", 64'(rd_pd), 64'h2AA_AAAA_AAAA);
    tick();
    chk("mid_end_count", 64'(fifo_count), 64'd0);
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random_stall();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
